ir_receiver: RTL and testbench



---
 rtl/ir_pkg.sv | 51 +++++
 rtl/ir_rx_edge_sync.sv | 36 +++
 rtl/ir_receiver.sv | 139 +++++++++++++
 tb/tb_ir_receiver.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared IR link definitions: FSM states, frame constants in units of BASE_DELAY,
// and the acceptance-window bounds the receiver classifies intervals against.
package ir_pkg;

  typedef enum logic [2:0] {
    IR_IDLE,
    IR_START,
    IR_SPACE,
    IR_MARK,
    IR_STOP
  } ir_state_e;

  localparam int IR_WORD_W   = 32;
  localparam int IR_START_U  = 2;
  localparam int IR_SPACE0_U = 1;
  localparam int IR_SPACE1_U = 3;
  localparam int IR_MARK_U   = 1;
  localparam int IR_STOP_U   = 3;

  // Start window is [3U/2, 5U/2): +/-25% around the 2U nominal.
  function automatic int start_lo(input int u);
    return (3 * IR_START_U * u) / 4;
  endfunction

  function automatic int start_hi(input int u);
    return (5 * IR_START_U * u) / 4;
  endfunction

  // Short intervals (nominal 1U) accept [U/2, 2U).
  function automatic int short_lo(input int units, input int u);
    return (units * u) / 2;
  endfunction

  function automatic int short_hi(input int units, input int u);
    return 2 * units * u;
  endfunction

  // Long intervals (nominal 3U) accept [2U, 4U).
  function automatic int long_lo(input int units, input int u);
    return (units - 1) * u;
  endfunction

  function automatic int long_hi(input int units, input int u);
    return (units + 1) * u;
  endfunction

  function automatic logic in_window(input int w, input int lo, input int hi);
    return (w >= lo) && (w < hi);
  endfunction

endpackage

// File: rtl/ir_rx_edge_sync.sv
// Two-flop synchroniser for the raw IR line plus single-cycle rise/fall pulses
// derived from the synchronised level.
module ir_rx_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic rx_port,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rx_port;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/ir_receiver.sv
// Pulse-distance IR frame decoder: measures each mark/space on the synchronised
// line, classifies it against BASE_DELAY windows and assembles a 32-bit word.
module ir_receiver
  import ir_pkg::*;
#(
  parameter int BASE_DELAY = 250
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_port,
  output logic [IR_WORD_W-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_error,
  output logic                 rx_busy
);

  localparam int CNT_MAX  = 4 * BASE_DELAY;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int ST_LO    = start_lo(BASE_DELAY);
  localparam int ST_HI    = start_hi(BASE_DELAY);
  localparam int SP0_LO   = short_lo(IR_SPACE0_U, BASE_DELAY);
  localparam int SP0_HI   = short_hi(IR_SPACE0_U, BASE_DELAY);
  localparam int SP1_LO   = long_lo(IR_SPACE1_U, BASE_DELAY);
  localparam int SP1_HI   = long_hi(IR_SPACE1_U, BASE_DELAY);
  localparam int MK_LO    = short_lo(IR_MARK_U, BASE_DELAY);
  localparam int MK_HI    = short_hi(IR_MARK_U, BASE_DELAY);
  localparam int STP_LO   = long_lo(IR_STOP_U, BASE_DELAY);
  localparam int STP_HI   = long_hi(IR_STOP_U, BASE_DELAY);

  logic rise, fall;

  ir_rx_edge_sync u_edge_sync (
    .clock  (clock),
    .reset  (reset),
    .rx_port(rx_port),
    .rise   (rise),
    .fall   (fall)
  );

  ir_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [IR_WORD_W-1:0] shift_q, shift_d;
  logic [IR_WORD_W-1:0] rx_data_q, rx_data_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;
  logic                 edge_seen, timeout, bad;
  int                   width;

  always_comb begin
    width     = int'(cnt_q);
    edge_seen = rise | fall;
    // An edge landing on the saturation cycle is classified (and rejected), not timed out.
    timeout   = (cnt_q == CNT_W'(CNT_MAX)) && !edge_seen;
    if (edge_seen)                        cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_W'(CNT_MAX))    cnt_d = cnt_q;
    else                                  cnt_d = cnt_q + CNT_W'(1);

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    busy_d    = busy_q;
    bad       = 1'b0;

    case (state_q)
      IR_IDLE: if (rise) begin
        state_d = IR_START;
        busy_d  = 1'b1;
      end
      IR_START: if (fall) begin
        if (in_window(width, ST_LO, ST_HI)) begin
          state_d   = IR_SPACE;
          bit_cnt_d = 5'd31;
        end else bad = 1'b1;
      end
      IR_SPACE: if (rise) begin
        if (in_window(width, SP0_LO, SP0_HI))      shift_d = {shift_q[IR_WORD_W-2:0], 1'b0};
        else if (in_window(width, SP1_LO, SP1_HI)) shift_d = {shift_q[IR_WORD_W-2:0], 1'b1};
        else                                       bad     = 1'b1;
        state_d = (bit_cnt_q == 5'd0) ? IR_STOP : IR_MARK;
      end
      IR_MARK: if (fall) begin
        if (in_window(width, MK_LO, MK_HI)) begin
          bit_cnt_d = bit_cnt_q - 5'd1;
          state_d   = IR_SPACE;
        end else bad = 1'b1;
      end
      IR_STOP: if (fall) begin
        if (in_window(width, STP_LO, STP_HI)) begin
          rx_data_d = shift_q;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = IR_IDLE;
        end else bad = 1'b1;
      end
      default: state_d = IR_IDLE;
    endcase

    if (state_q != IR_IDLE && (bad || timeout)) begin
      state_d = IR_IDLE;
      error_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IR_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = valid_q;
  assign rx_error = error_q;
  assign rx_busy  = busy_q;

endmodule

// File: tb/tb_ir_receiver.sv
// Bench for ir_receiver: line waveforms are built as lists of (level, duration)
// intervals and decoded by an interval-walking reference model.
module tb_ir_receiver;

  localparam int U = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_port;
  logic [31:0] rx_data;
  logic        rx_valid, rx_error, rx_busy;

  ir_receiver #(.BASE_DELAY(U)) dut (
    .clock   (clock),
    .reset   (reset),
    .rx_port (rx_port),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_error(rx_error),
    .rx_busy (rx_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
    logic [31:0] data;
  } evt_t;

  evt_t        exp_q[$], obs_q[$];
  bit          seg_lvl[$];
  int          seg_dur[$];
  int          bs_q[$], be_q[$];
  bit          rec = 0, busy_chk = 0;
  int          busy_bad, both_hi;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] last_data = 32'h0;

  always @(negedge clock) begin
    if (rec) begin
      bit   eb;
      evt_t ev;
      eb = 1'b0;
      foreach (bs_q[i]) if (cyc >= bs_q[i] && cyc < be_q[i]) eb = 1'b1;
      if (busy_chk && rx_busy !== eb) busy_bad++;
      if (rx_valid === 1'b1 && rx_error === 1'b1) both_hi++;
      if (rx_valid === 1'b1) begin
        ev.cyc = 32'(cyc); ev.err = 1'b0; ev.data = rx_data;
        obs_q.push_back(ev);
      end
      if (rx_error === 1'b1) begin
        ev.cyc = 32'(cyc); ev.err = 1'b1; ev.data = 32'h0;
        obs_q.push_back(ev);
      end
    end
  end

  task automatic push_seg(input bit l, input int d);
    if (seg_lvl.size() > 0 && seg_lvl[seg_lvl.size()-1] == l)
      seg_dur[seg_dur.size()-1] += d;
    else begin
      seg_lvl.push_back(l);
      seg_dur.push_back(d);
    end
  endtask

  task automatic push_frame(input logic [31:0] w, input bit jitter);
    push_seg(1'b1, jitter ? $urandom_range(15, 24) : 2 * U);
    for (int b = 31; b >= 0; b--) begin
      if (w[b]) push_seg(1'b0, jitter ? $urandom_range(20, 39) : 3 * U);
      else      push_seg(1'b0, jitter ? $urandom_range(5, 19) : U);
      if (b == 0) push_seg(1'b1, jitter ? $urandom_range(20, 39) : 3 * U);
      else        push_seg(1'b1, jitter ? $urandom_range(5, 19) : U);
    end
  endtask

  task automatic clear_segs();
    seg_lvl.delete();
    seg_dur.delete();
  endtask

  // Reference decoder: segment m starts on drive cycle T[m]; an output reacting to the
  // interval boundary at T[m] is seen 3 cycles later (2 sync flops + registered output).
  task automatic model(input int base);
    int          T[$];
    int          n, k, i, d, lo, hi, t;
    bit          done;
    logic [31:0] sh;
    evt_t        ev;
    exp_q.delete(); bs_q.delete(); be_q.delete();
    n = seg_lvl.size();
    t = base;
    for (int m = 0; m < n; m++) begin T.push_back(t); t += seg_dur[m]; end
    T.push_back(t);
    k = 0;
    while (k < n) begin
      if (seg_lvl[k] == 1'b0) begin k++; continue; end
      bs_q.push_back(T[k] + 3);
      sh = 32'h0;
      done = 1'b0;
      for (int j = 0; j < 65 && !done; j++) begin
        i = k + j;
        if (i >= n) begin
          be_q.push_back(1 << 30); done = 1'b1; k = n;
        end else begin
          d = seg_dur[i];
          if (j == 0)             begin lo = 3 * U / 2; hi = 5 * U / 2; end
          else if (j % 2 == 1)    begin lo = U / 2;     hi = 4 * U;     end
          else if (j == 64)       begin lo = 2 * U;     hi = 4 * U;     end
          else                    begin lo = U / 2;     hi = 2 * U;     end
          if (d > 4 * U) begin
            ev.cyc = 32'(T[i] + 4 * U + 3); ev.err = 1'b1; ev.data = 32'h0;
            exp_q.push_back(ev); be_q.push_back(T[i] + 4 * U + 3);
            k = i + 1; done = 1'b1;
          end else if (d < lo || d >= hi) begin
            ev.cyc = 32'(T[i+1] + 3); ev.err = 1'b1; ev.data = 32'h0;
            exp_q.push_back(ev); be_q.push_back(T[i+1] + 3);
            k = i + 2; done = 1'b1;
          end else if (j % 2 == 1) begin
            sh = {sh[30:0], (d >= 2 * U)};
          end
        end
      end
      if (!done) begin
        ev.cyc = 32'(T[k+65] + 3); ev.err = 1'b0; ev.data = sh;
        exp_q.push_back(ev); be_q.push_back(T[k+65] + 3);
        last_data = sh;
        k += 65;
      end
    end
  endtask

  task automatic run_segs();
    int base;
    push_seg(1'b0, 50);
    @(posedge clock); #1;
    base = cyc;
    model(base);
    obs_q.delete(); busy_bad = 0; both_hi = 0; rec = 1; busy_chk = 1;
    foreach (seg_lvl[k]) begin
      rx_port = seg_lvl[k];
      repeat (seg_dur[k]) begin @(posedge clock); #1; end
    end
    repeat (4) begin @(posedge clock); #1; end
    rec = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_port = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_tests++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, want 0", rx_data); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, want 0", rx_valid); end
    n_tests++; if (rx_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b, want 0", rx_error); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, want 0", rx_busy); end
    @(posedge clock); #1; reset = 1'b0;
    repeat (45) @(posedge clock);
  endtask

  task automatic test_nominal();
    clear_segs();
    push_frame(32'hA5A5_1234, 1'b0);
    run_segs();
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL nominal_count: got %0d pulses, want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL nominal_pulse%0d: got cyc=%0d err=%b data=%h, want cyc=%0d err=%b data=%h", i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data); end
    end
    n_tests++;
    if (busy_bad != 0 || both_hi != 0) begin n_fail++; $display("FAIL nominal_busy: got %0d busy mismatches and %0d overlaps, want 0", busy_bad, both_hi); end
    n_tests++;
    if (rx_data !== 32'hA5A5_1234) begin n_fail++; $display("FAIL nominal_data: got %h, want a5a51234", rx_data); end
  endtask

  task automatic test_back_to_back();
    clear_segs();
    push_frame(32'h0000_0000, 1'b0);
    push_seg(1'b0, 1);
    push_frame(32'hFFFF_FFFF, 1'b0);
    run_segs();
    n_tests++;
    if (obs_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d pulses, want 2", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_pulse%0d: got cyc=%0d err=%b data=%h, want cyc=%0d err=%b data=%h", i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data); end
    end
    n_tests++;
    if (busy_bad != 0 || both_hi != 0) begin n_fail++; $display("FAIL b2b_busy: got %0d busy mismatches and %0d overlaps, want 0", busy_bad, both_hi); end
  endtask

  task automatic test_boundary();
    logic [31:0] w, prev;
    w = $urandom();
    clear_segs();
    push_frame(w, 1'b0);
    seg_dur[1] = 20;
    seg_dur[3] = 19;
    push_seg(1'b0, 3);
    // Second frame sits on every lower bound: start 15, short 5, long 20, stop 20.
    push_frame(~w, 1'b0);
    for (int m = 66; m < seg_dur.size(); m++) begin
      if (m == 66)                       seg_dur[m] = 15;
      else if (m == 130)                 seg_dur[m] = 20;
      else if (seg_lvl[m] == 1'b1)       seg_dur[m] = 5;
      else                               seg_dur[m] = (seg_dur[m] >= 2 * U) ? 20 : 5;
    end
    push_seg(1'b0, 3);
    push_seg(1'b1, 25);
    run_segs();
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bound_count: got %0d pulses, want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bound_pulse%0d: got cyc=%0d err=%b data=%h, want cyc=%0d err=%b data=%h", i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data); end
    end
    n_tests++;
    if (busy_bad != 0 || both_hi != 0) begin n_fail++; $display("FAIL bound_busy: got %0d busy mismatches and %0d overlaps, want 0", busy_bad, both_hi); end
    if (obs_q.size() > 0) begin
      n_tests++;
      if (obs_q[0].err !== 1'b0 || obs_q[0].data[31:30] !== 2'b10 || obs_q[0].data[29:0] !== w[29:0])
        begin n_fail++; $display("FAIL bound_space20_19: got %h, want %h", obs_q[0].data, {2'b10, w[29:0]}); end
    end
    prev = {~w[31:0]};
    n_tests++;
    if (rx_data !== prev) begin n_fail++; $display("FAIL bound_start25_keeps_data: got %h, want %h", rx_data, prev); end
  endtask

  task automatic test_glitch();
    clear_segs();
    push_seg(1'b1, 3);
    run_segs();
    n_tests++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL glitch_count: got %0d pulses, want 1", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL glitch_pulse%0d: got cyc=%0d err=%b data=%h, want cyc=%0d err=%b data=%h", i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data); end
    end
    n_tests++;
    if (busy_bad != 0 || both_hi != 0) begin n_fail++; $display("FAIL glitch_busy: got %0d busy mismatches and %0d overlaps, want 0", busy_bad, both_hi); end
  endtask

  task automatic test_stuck_high();
    clear_segs();
    push_frame($urandom(), 1'b0);
    while (seg_lvl.size() > 45) begin void'(seg_lvl.pop_back()); void'(seg_dur.pop_back()); end
    seg_dur[44] = 60;
    push_seg(1'b0, 5);
    push_frame(32'h0F0F_C3A5, 1'b0);
    run_segs();
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stuck_count: got %0d pulses, want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stuck_pulse%0d: got cyc=%0d err=%b data=%h, want cyc=%0d err=%b data=%h", i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data); end
    end
    n_tests++;
    if (busy_bad != 0 || both_hi != 0) begin n_fail++; $display("FAIL stuck_busy: got %0d busy mismatches and %0d overlaps, want 0", busy_bad, both_hi); end
    n_tests++;
    if (rx_data !== 32'h0F0F_C3A5) begin n_fail++; $display("FAIL stuck_recover_data: got %h, want 0f0fc3a5", rx_data); end
  endtask

  task automatic test_reset_mid_frame();
    clear_segs();
    push_frame($urandom(), 1'b0);
    while (seg_lvl.size() > 33) begin void'(seg_lvl.pop_back()); void'(seg_dur.pop_back()); end
    push_seg(1'b0, 5);
    @(posedge clock); #1;
    obs_q.delete(); bs_q.delete(); be_q.delete(); busy_chk = 0; both_hi = 0; rec = 1;
    foreach (seg_lvl[k]) begin
      rx_port = seg_lvl[k];
      repeat (seg_dur[k]) begin @(posedge clock); #1; end
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({rx_data, rx_valid, rx_error, rx_busy} !== 35'h0)
      begin n_fail++; $display("FAIL midreset_outputs: got data=%h v=%b e=%b b=%b, want all 0", rx_data, rx_valid, rx_error, rx_busy); end
    repeat (10) @(posedge clock);
    #1; rec = 0;
    last_data = 32'h0;
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL midreset_pulses: got %0d pulses, want 0", obs_q.size()); end
    clear_segs();
    push_frame(32'h1234_5678, 1'b0);
    run_segs();
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midreset_count: got %0d pulses, want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midreset_pulse%0d: got cyc=%0d err=%b data=%h, want cyc=%0d err=%b data=%h", i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data); end
    end
    n_tests++;
    if (rx_data !== 32'h1234_5678) begin n_fail++; $display("FAIL midreset_data: got %h, want 12345678", rx_data); end
  endtask

  task automatic test_random();
    int fs;
    for (int it = 0; it < 4; it++) begin
      clear_segs();
      for (int f = 0; f < 3; f++) begin
        fs = seg_lvl.size();
        push_frame($urandom(), 1'b1);
        if ($urandom_range(0, 1) == 1) seg_dur[fs + $urandom_range(0, 64)] = $urandom_range(1, 45);
        push_seg(1'b0, $urandom_range(1, 20));
      end
      run_segs();
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random%0d_count: got %0d pulses, want %0d", it, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random%0d_pulse%0d: got cyc=%0d err=%b data=%h, want cyc=%0d err=%b data=%h", it, i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data); end
      end
      n_tests++;
      if (busy_bad != 0 || both_hi != 0) begin n_fail++; $display("FAIL random%0d_busy: got %0d busy mismatches and %0d overlaps, want 0", it, busy_bad, both_hi); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_boundary();
    test_glitch();
    test_stuck_high();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
